mem_wb_skid: RTL and testbench

//  Elastic MEM->WB pipeline stage that replaces the fixed MEM/WB latch: a 2-entry skid

---
 rtl/mem_wb_skid_pkg.sv | 20 ++
 rtl/wb_slot.sv | 55 +++++
 rtl/mem_wb_skid.sv | 161 ++++++++++++++++
 tb/tb_mem_wb_skid.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_pkg.sv
// Shared definitions for the elastic MEM->WB stage.
//   RstnEnable     : level of the active-low reset input that means "in reset"
//   occ_e          : occupancy state, encoded as the number of entries held
//   stored_wreg()  : write enable as captured, after x0 suppression
package mem_wb_skid_pkg;

  localparam logic RstnEnable = 1'b0;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  function automatic logic stored_wreg(input logic wreg, input logic wd_is_x0,
                                       input logic suppress);
    return wreg & ~(suppress & wd_is_x0);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One writeback entry register: valid + destination + write enable + data.
//   clk, rst     : clock, asynchronous active-low reset
//   load_i       : capture wd/wreg/wdata and set valid
//   clear_i      : zero the whole entry (wins over load_i)
//   wd_i/wreg_i/wdata_i : entry to capture
//   valid_o/wd_o/wreg_o/wdata_o : stored entry
module wb_slot
  import mem_wb_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      wd_q    <= wd_i;
      wreg_q  <= wreg_i;
      wdata_q <= wdata_i;
    end
  end

  assign valid_o = valid_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_skid.sv
// Elastic MEM->WB stage: 2-entry skid register (main + skid) with valid/ready on
// both sides, synchronous flush, x0 write suppression and a saturating counter of
// full-and-stalled cycles. mem_ready is registered so WB stalls never form a
// combinational path back into MEM.
//   clk, rst (active-low async), flush
//   mem_valid/mem_ready, mem_wd/mem_wreg/mem_wdata : MEM side
//   wb_valid/wb_ready, wb_wd/wb_wreg/wb_wdata      : WB side (main entry only)
//   occ          : entries held (0..2)
//   stall_cycles : cycles spent full while WB was not ready, saturating
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 5,
  parameter bit          ZERO_SUPPRESS = 1'b1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cycles
);

  occ_e             state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic accept, consume;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic              in_wreg;
  logic [ADDR_W-1:0] main_wd_d;
  logic              main_wreg_d;
  logic [DATA_W-1:0] main_wdata_d;

  logic              main_valid, main_wreg;
  logic [ADDR_W-1:0] main_wd;
  logic [DATA_W-1:0] main_wdata;
  logic              skid_valid, skid_wreg;
  logic [ADDR_W-1:0] skid_wd;
  logic [DATA_W-1:0] skid_wdata;

  assign mem_ready = ~skid_valid;
  assign accept    = mem_valid & mem_ready;
  assign consume   = main_valid & wb_ready;
  assign in_wreg   = stored_wreg(mem_wreg, mem_wd == '0, ZERO_SUPPRESS);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = OccEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        OccEmpty: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = OccOne;
          end
        end
        OccOne: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = OccFull;
          end else if (consume) begin
            main_clear = 1'b1;
            state_d    = OccEmpty;
          end
        end
        OccFull: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = OccOne;
          end
        end
        default: state_d = OccEmpty;
      endcase
    end
  end

  // Draining from FULL refills main from skid; otherwise main takes MEM directly.
  always_comb begin
    main_wd_d    = main_from_skid ? skid_wd    : mem_wd;
    main_wreg_d  = main_from_skid ? skid_wreg  : in_wreg;
    main_wdata_d = main_from_skid ? skid_wdata : mem_wdata;
  end

  always_comb begin
    stall_d = stall_q;
    if (state_q == OccFull && !wb_ready && !flush && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstnEnable) begin
      state_q <= OccEmpty;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .wd_i    (main_wd_d),
    .wreg_i  (main_wreg_d),
    .wdata_i (main_wdata_d),
    .valid_o (main_valid),
    .wd_o    (main_wd),
    .wreg_o  (main_wreg),
    .wdata_o (main_wdata)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .wd_i    (mem_wd),
    .wreg_i  (in_wreg),
    .wdata_i (mem_wdata),
    .valid_o (skid_valid),
    .wd_o    (skid_wd),
    .wreg_o  (skid_wreg),
    .wdata_o (skid_wdata)
  );

  assign wb_valid     = main_valid;
  assign wb_wd        = main_wd;
  assign wb_wreg      = main_wreg & main_valid;
  assign wb_wdata     = main_wdata;
  assign occ          = state_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

  localparam int unsigned CNT_A = 4;
  localparam int unsigned CNT_B = 16;
  localparam int unsigned MAX_A = (1 << CNT_A) - 1;
  localparam int unsigned MAX_B = (1 << CNT_B) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_wd = '0;
  logic        mem_wreg = 1'b0;
  logic [31:0] mem_wdata = '0;
  logic        wb_ready = 1'b0;

  logic              mem_ready_a, wb_valid_a, wb_wreg_a;
  logic [4:0]        wb_wd_a;
  logic [31:0]       wb_wdata_a;
  logic [1:0]        occ_a;
  logic [CNT_A-1:0]  stall_a;
  logic              mem_ready_b, wb_valid_b, wb_wreg_b;
  logic [4:0]        wb_wd_b;
  logic [31:0]       wb_wdata_b;
  logic [1:0]        occ_b;
  logic [CNT_B-1:0]  stall_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int unsigned m_st_a = 0;
  int unsigned m_st_b = 0;

  always #5 clk = ~clk;

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b1), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready_a),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(wb_valid_a), .wb_ready(wb_ready),
    .wb_wd(wb_wd_a), .wb_wreg(wb_wreg_a), .wb_wdata(wb_wdata_a),
    .occ(occ_a), .stall_cycles(stall_a)
  );

  mem_wb_skid #(.DATA_W(32), .ADDR_W(5), .ZERO_SUPPRESS(1'b0), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready_b),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_valid(wb_valid_b), .wb_ready(wb_ready),
    .wb_wd(wb_wd_b), .wb_wreg(wb_wreg_b), .wb_wdata(wb_wdata_b),
    .occ(occ_b), .stall_cycles(stall_b)
  );

  // Reference: a FIFO of at most two entries; MEM may push only while fewer than
  // two are held (as seen at the start of the cycle), WB pops the head.
  task automatic step();
    int unsigned sz;
    bit acc, con;
    @(posedge clk);
    sz = q.size();
    if (!rst) begin
      q.delete();
      m_st_a = 0;
      m_st_b = 0;
    end else begin
      acc = mem_valid && (sz < 2);
      con = (sz > 0) && wb_ready;
      if (sz == 2 && !wb_ready && !flush) begin
        if (m_st_a < MAX_A) m_st_a++;
        if (m_st_b < MAX_B) m_st_b++;
      end
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(ent_t'{wd: mem_wd, wreg: mem_wreg, data: mem_wdata});
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    flush     = 1'b0;
    wb_ready  = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset
    rst = 1'b0;
    step(); step();
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL por_occ got=%0d exp=0", occ_a); end
    checks++; if (wb_valid_a !== 1'b0 || wb_wreg_a !== 1'b0) begin failures++; $display("FAIL por_wb got v=%b w=%b exp v=0 w=0", wb_valid_a, wb_wreg_a); end
    checks++; if (mem_ready_a !== 1'b1 || mem_ready_b !== 1'b1) begin failures++; $display("FAIL por_ready got=%b/%b exp=1", mem_ready_a, mem_ready_b); end
    checks++; if (stall_a !== '0) begin failures++; $display("FAIL por_stall got=%0d exp=0", stall_a); end
    rst = 1'b1;
    step();
    // fill to two entries, then stall one cycle
    wb_ready = 1'b0; mem_valid = 1'b1; mem_wreg = 1'b1;
    mem_wd = 5'd1; mem_wdata = 32'h11; step();
    mem_wd = 5'd2; mem_wdata = 32'h22; step();
    mem_valid = 1'b0; step();
    checks++; if (occ_a !== 2'd2 || stall_a !== 4'd1) begin failures++; $display("FAIL pre_reset got occ=%0d stall=%0d exp occ=2 stall=1", occ_a, stall_a); end
    // asynchronous reset away from the clock edge
    #2 rst = 1'b0;
    #1;
    checks++; if (occ_a !== 2'd0 || occ_b !== 2'd0) begin failures++; $display("FAIL async_rst_occ got=%0d/%0d exp=0", occ_a, occ_b); end
    checks++; if (wb_valid_a !== 1'b0 || mem_ready_a !== 1'b1) begin failures++; $display("FAIL async_rst_hs got v=%b r=%b exp v=0 r=1", wb_valid_a, mem_ready_a); end
    checks++; if (stall_a !== '0 || stall_b !== '0) begin failures++; $display("FAIL async_rst_stall got=%0d/%0d exp=0", stall_a, stall_b); end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    wb_ready = 1'b1; mem_valid = 1'b1; mem_wreg = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      mem_wd = 5'(i); mem_wdata = 32'h100 + 32'(i);
      step();
      checks++;
      if (wb_valid_a !== 1'b1 || wb_wd_a !== 5'(i) || wb_wdata_a !== 32'h100 + 32'(i) || mem_ready_a !== 1'b1)
        begin failures++; $display("FAIL stream_%0d got v=%b wd=%0d d=%h r=%b exp v=1 wd=%0d d=%h r=1", i, wb_valid_a, wb_wd_a, wb_wdata_a, mem_ready_a, i, 32'h100 + 32'(i)); end
    end
    mem_valid = 1'b0;
    step();
    checks++; if (occ_a !== 2'd0 || wb_valid_a !== 1'b0) begin failures++; $display("FAIL stream_drain got occ=%0d v=%b exp occ=0 v=0", occ_a, wb_valid_a); end
  endtask

  task automatic test_backpressure();
    logic [4:0] got[$];
    logic [4:0] exp_wd;
    bit sent;
    wb_ready = 1'b0; mem_valid = 1'b1; mem_wreg = 1'b1;
    mem_wd = 5'd3; mem_wdata = 32'h333; step();
    mem_wd = 5'd4; mem_wdata = 32'h444; step();
    checks++; if (occ_a !== 2'd2 || mem_ready_a !== 1'b0) begin failures++; $display("FAIL bp_full got occ=%0d r=%b exp occ=2 r=0", occ_a, mem_ready_a); end
    mem_wd = 5'd5; mem_wdata = 32'h555;
    step(); step(); step();
    checks++; if (stall_a !== 4'd3 || stall_b !== 16'd3) begin failures++; $display("FAIL bp_stall got=%0d/%0d exp=3", stall_a, stall_b); end
    checks++; if (wb_wd_a !== 5'd3 || occ_a !== 2'd2) begin failures++; $display("FAIL bp_hold got wd=%0d occ=%0d exp wd=3 occ=2", wb_wd_a, occ_a); end
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid_a) got.push_back(wb_wd_a);
      sent = mem_valid && mem_ready_a;
      step();
      if (sent) mem_valid = 1'b0;
    end
    checks++; if (got.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      exp_wd = 5'(3 + i);
      checks++; if (got[i] !== exp_wd) begin failures++; $display("FAIL bp_order_%0d got=%0d exp=%0d", i, got[i], exp_wd); end
    end
    checks++; if (stall_a !== 4'd3) begin failures++; $display("FAIL bp_stall_after got=%0d exp=3", stall_a); end
  endtask

  task automatic test_flush();
    wb_ready = 1'b0; mem_valid = 1'b1; mem_wreg = 1'b1;
    mem_wd = 5'd6; mem_wdata = 32'h666; step();
    mem_wd = 5'd7; mem_wdata = 32'h777; step();
    mem_wd = 5'd9; mem_wdata = 32'h999; wb_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; mem_valid = 1'b0;
    checks++; if (occ_a !== 2'd0 || wb_valid_a !== 1'b0) begin failures++; $display("FAIL flush_occ got occ=%0d v=%b exp occ=0 v=0", occ_a, wb_valid_a); end
    checks++; if (wb_wd_a !== 5'd0 || wb_wdata_a !== 32'd0 || wb_wd_b !== 5'd0) begin failures++; $display("FAIL flush_zero got wd=%0d d=%h exp 0", wb_wd_a, wb_wdata_a); end
    checks++; if (stall_a !== 4'd3) begin failures++; $display("FAIL flush_stall got=%0d exp=3", stall_a); end
    step();
    checks++; if (occ_a !== 2'd0 || mem_ready_a !== 1'b1) begin failures++; $display("FAIL flush_drop got occ=%0d r=%b exp occ=0 r=1", occ_a, mem_ready_a); end
  endtask

  task automatic test_x0();
    wb_ready = 1'b0; mem_valid = 1'b1;
    mem_wd = 5'd0; mem_wreg = 1'b1; mem_wdata = 32'hDEADBEEF;
    step();
    mem_valid = 1'b0;
    checks++; if (wb_valid_a !== 1'b1 || wb_wreg_a !== 1'b0 || wb_wdata_a !== 32'hDEADBEEF) begin failures++; $display("FAIL x0_suppress got v=%b w=%b d=%h exp v=1 w=0 d=deadbeef", wb_valid_a, wb_wreg_a, wb_wdata_a); end
    checks++; if (wb_valid_b !== 1'b1 || wb_wreg_b !== 1'b1) begin failures++; $display("FAIL x0_nosuppress got v=%b w=%b exp v=1 w=1", wb_valid_b, wb_wreg_b); end
    wb_ready = 1'b1; step(); step();
    checks++; if (occ_a !== 2'd0) begin failures++; $display("FAIL x0_drain got=%0d exp=0", occ_a); end
  endtask

  task automatic test_saturation();
    int unsigned exp_b;
    wb_ready = 1'b0; mem_valid = 1'b1; mem_wd = 5'd10; step(); step();
    mem_valid = 1'b0;
    exp_b = stall_b;
    for (int i = 0; i < 20; i++) step();
    checks++; if (stall_a !== 4'd15) begin failures++; $display("FAIL sat_a got=%0d exp=15", stall_a); end
    checks++; if (stall_b !== 16'(exp_b + 20)) begin failures++; $display("FAIL sat_b got=%0d exp=%0d", stall_b, exp_b + 20); end
    wb_ready = 1'b1; step(); step();
  endtask

  task automatic test_random();
    int unsigned sz;
    for (int n = 0; n < 500; n++) begin
      mem_valid = ($urandom_range(0, 9) < 6);
      wb_ready  = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 31) == 0);
      mem_wd    = 5'($urandom_range(0, 31));
      mem_wreg  = 1'($urandom_range(0, 1));
      mem_wdata = $urandom;
      step();
      sz = q.size();
      checks++;
      if (occ_a !== 2'(sz) || occ_b !== 2'(sz) || wb_valid_a !== (sz > 0) || mem_ready_a !== (sz < 2) || mem_ready_b !== (sz < 2))
        begin failures++; $display("FAIL rnd_state_%0d got occ=%0d v=%b r=%b exp occ=%0d", n, occ_a, wb_valid_a, mem_ready_a, sz); end
      checks++;
      if (stall_a !== CNT_A'(m_st_a) || stall_b !== CNT_B'(m_st_b))
        begin failures++; $display("FAIL rnd_stall_%0d got=%0d/%0d exp=%0d/%0d", n, stall_a, stall_b, m_st_a, m_st_b); end
      checks++;
      if (sz > 0) begin
        if (wb_wd_a !== q[0].wd || wb_wdata_a !== q[0].data || wb_wd_b !== q[0].wd || wb_wdata_b !== q[0].data ||
            wb_wreg_a !== (q[0].wreg && q[0].wd != 0) || wb_wreg_b !== q[0].wreg)
          begin failures++; $display("FAIL rnd_head_%0d got wd=%0d d=%h w=%b/%b exp wd=%0d d=%h", n, wb_wd_a, wb_wdata_a, wb_wreg_a, wb_wreg_b, q[0].wd, q[0].data); end
      end else if (wb_wreg_a !== 1'b0 || wb_wreg_b !== 1'b0) begin
        failures++; $display("FAIL rnd_empty_wreg_%0d got=%b/%b exp=0", n, wb_wreg_a, wb_wreg_b);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    idle_inputs();
    test_streaming();
    idle_inputs();
    test_backpressure();
    idle_inputs();
    test_flush();
    idle_inputs();
    test_x0();
    idle_inputs();
    test_saturation();
    idle_inputs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
